spi_tx_controller: RTL and testbench

//   Sequences a parallel-to-serial shift register as an SPI-style transmit master.

---
 rtl/spi_tx_controller_pkg.sv | 9 +
 rtl/spi_tx_controller_if.sv | 13 +
 rtl/spi_tx_controller_ps_shift_reg.sv | 16 +
 rtl/spi_tx_controller.sv | 84 ++++++++
 tb/tb_spi_tx_controller.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/spi_tx_controller_pkg.sv
// spi_tx_controller_pkg: shared state encoding, default sizing and counter-width helper
package spi_tx_controller_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} spi_state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CLK_DIV = 2;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_tx_controller_if.sv
// spi_tx_controller_if: word handshake plus SPI pins between source and transmit controller
interface spi_tx_controller_if import spi_tx_controller_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic busy;
  logic done;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  modport master (output tx_data, tx_valid, input tx_ready, busy, done, spi_cs_n, spi_sclk, spi_mosi);
  modport slave (input tx_data, tx_valid, output tx_ready, busy, done, spi_cs_n, spi_sclk, spi_mosi);
endinterface

// File: rtl/spi_tx_controller_ps_shift_reg.sv
// ps_shift_reg: parallel-load, MSB-first shift-left register with zero fill
module ps_shift_reg import spi_tx_controller_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clock)
    if (reset) q <= '0;
    else if (load) q <= par_in;
    else if (shift) q <= q << 1;
  assign ser_out = q[WIDTH-1];
endmodule

// File: rtl/spi_tx_controller.sv
// spi_tx_controller: mode-0 SPI transmit master sequencing a shift register, one word per handshake
module spi_tx_controller import spi_tx_controller_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic clock,
  input logic reset,
  spi_tx_controller_if.slave bus
);
  localparam int BW = cnt_w(WIDTH);
  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  spi_state_t state, state_d;
  logic [BW-1:0] bit_cnt, bit_d;
  logic [DW-1:0] div_cnt, div_d;
  logic sclk_d, load, shift, tick, active_d;
  assign tick = div_cnt == DIV_LAST;
  assign load = state == IDLE && bus.tx_valid && bus.tx_ready;
  assign active_d = state_d inside {LEAD, SHIFT, TRAIL};
  always_comb begin
    state_d = state;
    bit_d = bit_cnt;
    div_d = tick ? '0 : div_cnt + 1'b1;
    sclk_d = bus.spi_sclk;
    shift = 1'b0;
    case (state)
      IDLE: begin
        div_d = '0;
        if (load) begin
          state_d = LEAD;
          bit_d = BIT_LAST;
        end
      end
      LEAD: state_d = tick ? SHIFT : LEAD;
      SHIFT: if (tick) begin
        sclk_d = !bus.spi_sclk;
        // falling toggle: either retire the last bit or present the next one
        if (bus.spi_sclk) begin
          if (bit_cnt == '0) state_d = TRAIL;
          else begin
            shift = 1'b1;
            bit_d = bit_cnt - 1'b1;
          end
        end
      end
      TRAIL: state_d = tick ? DONE : TRAIL;
      DONE: begin
        div_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      bus.tx_ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.spi_cs_n <= 1'b1;
      bus.spi_sclk <= 1'b0;
    end else begin
      state <= state_d;
      bit_cnt <= bit_d;
      div_cnt <= div_d;
      bus.tx_ready <= state_d == IDLE;
      bus.busy <= state_d != IDLE;
      bus.done <= state_d == DONE;
      bus.spi_cs_n <= !active_d;
      bus.spi_sclk <= sclk_d;
    end
  // mosi comes straight from the shift register flop, so it changes with the falling toggle
  ps_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clock(clock),
    .reset(reset),
    .load(load),
    .shift(shift),
    .par_in(bus.tx_data),
    .ser_out(bus.spi_mosi)
  );
endmodule

// File: tb/tb_spi_tx_controller.sv
// tb_spi_tx_controller: scoreboard bench for a 4-bit/div-2 and an 8-bit/div-1 controller
module tb_spi_tx_controller;
  logic clk = 0, rst = 1;
  int cyc = 0, n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  spi_tx_controller_if #(.WIDTH(4)) a_if();
  spi_tx_controller_if #(.WIDTH(8)) b_if();
  spi_tx_controller #(.WIDTH(4), .CLK_DIV(2)) dut_a (.clock(clk), .reset(rst), .bus(a_if.slave));
  spi_tx_controller #(.WIDTH(8), .CLK_DIV(1)) dut_b (.clock(clk), .reset(rst), .bus(b_if.slave));
  typedef struct {int id; logic [7:0] word; int lat; int width;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  logic [7:0] mask;
  logic sclk[2], mosi[2], done[2], rdy[2], vld[2], cs[2], busy[2];
  assign sclk[0] = a_if.spi_sclk; assign sclk[1] = b_if.spi_sclk;
  assign mosi[0] = a_if.spi_mosi; assign mosi[1] = b_if.spi_mosi;
  assign done[0] = a_if.done;     assign done[1] = b_if.done;
  assign rdy[0] = a_if.tx_ready;  assign rdy[1] = b_if.tx_ready;
  assign vld[0] = a_if.tx_valid;  assign vld[1] = b_if.tx_valid;
  assign cs[0] = a_if.spi_cs_n;   assign cs[1] = b_if.spi_cs_n;
  assign busy[0] = a_if.busy;     assign busy[1] = b_if.busy;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // monitor: collect mosi at each sclk rise, score the stream and timing on done
  logic [7:0] bits[2];
  int nbits[2], t0[2], cs_low[2];
  logic sclk_p[2], mosi_p[2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst === 1'b1) nbits[k] = 0;
      if (sclk[k] === 1'b1 && sclk_p[k] === 1'b0) begin
        bits[k] = {bits[k][6:0], mosi[k]};
        nbits[k]++;
        chk("mosi_stable_at_rise", mosi[k], mosi_p[k]);
      end
      if (cs[k] === 1'b0) cs_low[k]++;
      if (done[k] === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          cur = exp_q.pop_front();
          mask = 8'hFF >> (8 - cur.width);
          chk("done_dut", k, cur.id);
          chk("stream", bits[k] & mask, cur.word);
          chk("rise_count", nbits[k], cur.width);
          chk("done_latency", cyc - t0[k], cur.lat);
          chk("cs_low_cycles", cs_low[k], cur.lat - 1);
        end
      end
      if (vld[k] === 1'b1 && rdy[k] === 1'b1 && rst === 1'b0) begin
        t0[k] = cyc;
        nbits[k] = 0;
        cs_low[k] = 0;
      end
      sclk_p[k] = sclk[k];
      mosi_p[k] = mosi[k];
    end
  end
  task automatic drive(input int k, input logic [7:0] w, input logic v);
    if (k == 0) begin a_if.tx_data = w[3:0]; a_if.tx_valid = v; end
    else begin b_if.tx_data = w; b_if.tx_valid = v; end
  endtask
  task automatic send(input int k, input logic [7:0] w, input int lat, input int width);
    exp_q.push_back('{k, w, lat, width});
    drive(k, w, 1'b1);
    @(posedge clk); #1;
    drive(k, w, 1'b0);
  endtask
  task automatic wait_done(input int k, input int limit);
    int i = 0;
    do begin @(negedge clk); i++; end while (done[k] !== 1'b1 && i < limit);
    chk("done_seen", done[k], 1'b1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    logic ok, seen;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {rdy[0], busy[0], done[0], cs[0], sclk[0], mosi[0]}, 6'b100100);
    chk("reset_b", {rdy[1], busy[1], done[1], cs[1], sclk[1], mosi[1]}, 6'b100100);
    drive(0, 8'h0F, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h0F, 1'b0);
    rst = 0;
    @(negedge clk);
    chk("reset_beats_accept", {rdy[0], busy[0], cs[0]}, 3'b101);
    repeat (10) begin
      @(negedge clk);
      chk("idle_quiet", {sclk[0], cs[0], done[0], rdy[0]}, 4'b0101);
    end
    @(posedge clk); #1;
    send(0, 8'h0E, 21, 4);
    wait_done(0, 40);
    @(posedge clk); #1;
    exp_q.push_back('{0, 8'h0A, 21, 4});
    exp_q.push_back('{0, 8'h05, 21, 4});
    drive(0, 8'h0A, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h05, 1'b1);
    wait_done(0, 40);
    chk("ready_low_in_done", rdy[0], 1'b0);
    @(negedge clk);
    chk("ready_after_done", rdy[0], 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h05, 1'b0);
    @(negedge clk);
    chk("second_accepted", busy[0], 1'b1);
    wait_done(0, 40);
    @(posedge clk); #1;
    exp_q.push_back('{0, 8'h0E, 21, 4});
    drive(0, 8'h0E, 1'b1);
    @(posedge clk); #1;
    ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy[0] !== 1'b0) ok = 0;
      if (i == 4) drive(0, 8'h00, 1'b1);
      if (i == 14) drive(0, 8'h00, 1'b0);
    end
    chk("ready_low_busy", ok, 1'b1);
    wait_done(0, 5);
    @(posedge clk); #1;
    drive(0, 8'h0E, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h0E, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("reset_mid", {cs[0], sclk[0], rdy[0], busy[0], done[0]}, 5'b10100);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen = 1;
    end
    chk("no_done_after_reset", seen, 1'b0);
    @(posedge clk); #1;
    send(1, 8'hA5, 19, 8);
    wait_done(1, 40);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
